reg_file_2r1w: RTL and testbench

Parametrised register file with two registered read ports and one write port, replacing the single-port, fixed-size memory in the CPU datapath. Memory contents are cleared after every reset by an internal scrub sequencer, and read data is qualified by a valid strobe. Sits between the decode stage (read addresses) and writeback (write port).

---
 rtl/reg_file_2r1w.sv | 116 +++++++++++
 tb/tb_reg_file_2r1w.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: WIDTH x 2**AW register file, two registered read ports, one write port.
// After every reset an internal scrub sequencer writes zero to every word (BUSY high)
// before accesses are accepted. Read data is qualified by VALID one cycle after the read.
// Optional feature macro: REGFILE_BYPASS_EN selects write-first forwarding on a
// same-cycle, same-address write/read; without it reads return the old contents.

module reg_file_2r1w #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ON,
    input  logic             W,
    input  logic [AW-1:0]    WADDR,
    input  logic [WIDTH-1:0] DATA_IN,
    input  logic             RE,
    input  logic [AW-1:0]    RADDR_A,
    input  logic [AW-1:0]    RADDR_B,
    output logic [WIDTH-1:0] DATA_OUT_A,
    output logic [WIDTH-1:0] DATA_OUT_B,
    output logic             VALID,
    output logic             BUSY
);

    localparam int unsigned DEPTH = 2 ** AW;

    typedef enum logic {StClear, StReady} state_e;

    state_e           state_q, state_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0] data_a_q, data_a_d;
    logic [WIDTH-1:0] data_b_q, data_b_d;
    logic             valid_q, valid_d;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             wr_acc, rd_acc;
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] rd_a, rd_b;

    // Access qualification, memory write port mux (scrub vs. user) and read-data selection
    always_comb begin
        wr_acc    = (state_q == StReady) && ON && W;
        rd_acc    = (state_q == StReady) && ON && RE;
        mem_we    = (state_q == StClear) || wr_acc;
        mem_waddr = (state_q == StClear) ? cnt_q[AW-1:0] : WADDR;
        mem_wdata = (state_q == StClear) ? '0 : DATA_IN;
        rd_a      = mem_q[RADDR_A];
        rd_b      = mem_q[RADDR_B];
`ifdef REGFILE_BYPASS_EN
        // Write-first: forward the word being written to a port reading the same address
        if (wr_acc && (WADDR == RADDR_A)) rd_a = DATA_IN;
        if (wr_acc && (WADDR == RADDR_B)) rd_b = DATA_IN;
`endif
    end

    // Next-state for scrub sequencer and registered read outputs
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        data_a_d = data_a_q;
        data_b_d = data_b_q;
        valid_d  = 1'b0;
        unique case (state_q)
            StClear: begin
                cnt_d    = cnt_q + 1'b1;
                data_a_d = '0;
                data_b_d = '0;
                if (cnt_q == (AW + 1)'(DEPTH - 1)) begin
                    state_d = StReady;
                end
            end
            StReady: begin
                if (rd_acc) begin
                    data_a_d = rd_a;
                    data_b_d = rd_b;
                    valid_d  = 1'b1;
                end
            end
            default: state_d = StClear;
        endcase
    end

    // Control and output registers, asynchronously returned to the scrub start
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= StClear;
            cnt_q    <= '0;
            data_a_q <= '0;
            data_b_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            data_a_q <= data_a_d;
            data_b_q <= data_b_d;
            valid_q  <= valid_d;
        end
    end

    // Storage array; no reset, contents are cleared by the scrub sequencer
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign DATA_OUT_A = data_a_q;
    assign DATA_OUT_B = data_b_q;
    assign VALID      = valid_q;
    assign BUSY       = (state_q == StClear);

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Testbench for reg_file_2r1w (WIDTH=16, AW=4). Expected read results are pushed to a
// queue as each cycle's stimulus is driven and popped once the registered output appears.

module tb_reg_file_2r1w;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ON = 1'b0;
    logic        W = 1'b0;
    logic [3:0]  WADDR = '0;
    logic [15:0] DATA_IN = '0;
    logic        RE = 1'b0;
    logic [3:0]  RADDR_A = '0;
    logic [3:0]  RADDR_B = '0;
    logic [15:0] DATA_OUT_A;
    logic [15:0] DATA_OUT_B;
    logic        VALID;
    logic        BUSY;

`ifdef REGFILE_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    typedef struct {
        logic        v;
        logic [15:0] a;
        logic [15:0] b;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] mdl [16];
    logic [15:0] last_a, last_b;
    int          errors = 0;
    int          checks = 0;

    reg_file_2r1w #(.WIDTH(16), .AW(4)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .ON         (ON),
        .W          (W),
        .WADDR      (WADDR),
        .DATA_IN    (DATA_IN),
        .RE         (RE),
        .RADDR_A    (RADDR_A),
        .RADDR_B    (RADDR_B),
        .DATA_OUT_A (DATA_OUT_A),
        .DATA_OUT_B (DATA_OUT_B),
        .VALID      (VALID),
        .BUSY       (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) mdl[i] = 16'h0000;
        last_a = 16'h0000;
        last_b = 16'h0000;
        exp_q.delete();
    endtask

    // Drive one cycle of stimulus, record the expected registered result, advance one edge
    task automatic drive(input logic on, input logic w, input logic [3:0] wa,
                         input logic [15:0] din, input logic re,
                         input logic [3:0] ra, input logic [3:0] rb);
        exp_t e;
        ON = on; W = w; WADDR = wa; DATA_IN = din; RE = re; RADDR_A = ra; RADDR_B = rb;
        if (on && re) begin
            e.v = 1'b1;
            e.a = mdl[ra];
            e.b = mdl[rb];
            if (Bypass && w && (wa == ra)) e.a = din;
            if (Bypass && w && (wa == rb)) e.b = din;
        end else begin
            e.v = 1'b0;
            e.a = last_a;
            e.b = last_b;
        end
        last_a = e.a;
        last_b = e.b;
        if (on && w) mdl[wa] = din;
        exp_q.push_back(e);
        tick();
        ON = 1'b1; W = 1'b0; RE = 1'b0;
    endtask

    // Release RST and count edges until BUSY falls; optionally hammer W/RE while busy
    task automatic run_scrub(input string name, input bit poke);
        int  n;
        bit  saw_valid;
        n = 0;
        saw_valid = 1'b0;
        RST = 1'b0;
        ON = 1'b1; W = poke; RE = poke; WADDR = 4'd0; DATA_IN = 16'hFFFF;
        RADDR_A = 4'd0; RADDR_B = 4'd0;
        while (n < 40) begin
            tick();
            n++;
            if (VALID !== 1'b0) saw_valid = 1'b1;
            if (BUSY !== 1'b1) break;
        end
        W = 1'b0; RE = 1'b0;
        checks++;
        if (n != 16 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL %s scrub_len: got %0d edges (BUSY=%b), want 16 edges then BUSY=0",
                     name, n, BUSY);
        end
        checks++;
        if (saw_valid) begin
            errors++;
            $display("FAIL %s valid_during_scrub: got VALID=1, want 0", name);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick();
        clear_model();
        checks++;
        if ({BUSY, VALID, DATA_OUT_A, DATA_OUT_B} !== {1'b1, 1'b0, 16'h0, 16'h0}) begin
            errors++;
            $display("FAIL reset_values: got BUSY=%b VALID=%b A=%h B=%h, want 1 0 0000 0000",
                     BUSY, VALID, DATA_OUT_A, DATA_OUT_B);
        end
        // Writes/reads (0xFFFF to addr 0) during scrub must be ignored
        run_scrub("reset", 1'b1);
    endtask

    task automatic test_scrub_readback();
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 4'd0, 16'h0, 1'b1, 4'(i), 4'(15 - i));
            e = exp_q.pop_front();
            checks++;
            if ({VALID, DATA_OUT_A, DATA_OUT_B} !== {e.v, e.a, e.b} || e.a !== 16'h0) begin
                errors++;
                $display("FAIL scrub_read[%0d]: got V=%b A=%h B=%h, want V=1 A=0000 B=0000",
                         i, VALID, DATA_OUT_A, DATA_OUT_B);
            end
        end
    endtask

    task automatic test_write_read();
        exp_t e;
        drive(1'b1, 1'b1, 4'd3, 16'hBEEF, 1'b0, 4'd0, 4'd0);
        e = exp_q.pop_front();
        drive(1'b1, 1'b0, 4'd0, 16'h0, 1'b1, 4'd3, 4'd3);
        e = exp_q.pop_front();
        checks++;
        if ({VALID, DATA_OUT_A, DATA_OUT_B} !== {1'b1, 16'hBEEF, 16'hBEEF}) begin
            errors++;
            $display("FAIL write_read: got V=%b A=%h B=%h, want V=1 A=beef B=beef",
                     VALID, DATA_OUT_A, DATA_OUT_B);
        end
        drive(1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd0);
        e = exp_q.pop_front();
        checks++;
        if ({VALID, DATA_OUT_A, DATA_OUT_B} !== {1'b0, 16'hBEEF, 16'hBEEF}) begin
            errors++;
            $display("FAIL idle_hold: got V=%b A=%h B=%h, want V=0 A=beef B=beef",
                     VALID, DATA_OUT_A, DATA_OUT_B);
        end
    endtask

    task automatic test_same_addr();
        exp_t        e;
        logic [15:0] want_a;
        want_a = Bypass ? 16'h2222 : 16'h1111;
        drive(1'b1, 1'b1, 4'd5, 16'h1111, 1'b0, 4'd0, 4'd0);
        e = exp_q.pop_front();
        drive(1'b1, 1'b1, 4'd5, 16'h2222, 1'b1, 4'd5, 4'd3);
        e = exp_q.pop_front();
        checks++;
        if ({VALID, DATA_OUT_A, DATA_OUT_B} !== {1'b1, want_a, 16'hBEEF}) begin
            errors++;
            $display("FAIL same_addr: got V=%b A=%h B=%h, want V=1 A=%h B=beef",
                     VALID, DATA_OUT_A, DATA_OUT_B, want_a);
        end
        drive(1'b1, 1'b0, 4'd0, 16'h0, 1'b1, 4'd5, 4'd5);
        e = exp_q.pop_front();
        checks++;
        if ({VALID, DATA_OUT_A, DATA_OUT_B} !== {1'b1, 16'h2222, 16'h2222}) begin
            errors++;
            $display("FAIL same_addr_next: got V=%b A=%h B=%h, want V=1 A=2222 B=2222",
                     VALID, DATA_OUT_A, DATA_OUT_B);
        end
    endtask

    task automatic test_disable();
        exp_t e;
        drive(1'b0, 1'b1, 4'd7, 16'hAAAA, 1'b1, 4'd7, 4'd7);
        e = exp_q.pop_front();
        checks++;
        if ({VALID, DATA_OUT_A, DATA_OUT_B} !== {1'b0, 16'h2222, 16'h2222}) begin
            errors++;
            $display("FAIL disabled: got V=%b A=%h B=%h, want V=0 A=2222 B=2222",
                     VALID, DATA_OUT_A, DATA_OUT_B);
        end
        drive(1'b1, 1'b0, 4'd0, 16'h0, 1'b1, 4'd7, 4'd5);
        e = exp_q.pop_front();
        checks++;
        if ({VALID, DATA_OUT_A, DATA_OUT_B} !== {1'b1, 16'h0000, 16'h2222}) begin
            errors++;
            $display("FAIL disabled_no_write: got V=%b A=%h B=%h, want V=1 A=0000 B=2222",
                     VALID, DATA_OUT_A, DATA_OUT_B);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 60; i++) begin
            drive(($urandom_range(0, 7) != 0), 1'($urandom), 4'($urandom),
                  16'($urandom), 1'($urandom), 4'($urandom), 4'($urandom));
            e = exp_q.pop_front();
            checks++;
            if ({VALID, DATA_OUT_A, DATA_OUT_B} !== {e.v, e.a, e.b}) begin
                errors++;
                $display("FAIL random[%0d]: got V=%b A=%h B=%h, want V=%b A=%h B=%h",
                         i, VALID, DATA_OUT_A, DATA_OUT_B, e.v, e.a, e.b);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        drive(1'b1, 1'b1, 4'd9, 16'h1234, 1'b0, 4'd0, 4'd0);
        e = exp_q.pop_front();
        drive(1'b1, 1'b0, 4'd0, 16'h0, 1'b1, 4'd9, 4'd9);
        e = exp_q.pop_front();
        checks++;
        if ({VALID, DATA_OUT_A} !== {1'b1, 16'h1234}) begin
            errors++;
            $display("FAIL pre_reset_read: got V=%b A=%h, want V=1 A=1234", VALID, DATA_OUT_A);
        end
        // Asynchronous: outputs must clear without a clock edge
        RST = 1'b1;
        #1;
        checks++;
        if ({BUSY, VALID, DATA_OUT_A, DATA_OUT_B} !== {1'b1, 1'b0, 16'h0, 16'h0}) begin
            errors++;
            $display("FAIL async_reset: got BUSY=%b VALID=%b A=%h B=%h, want 1 0 0000 0000",
                     BUSY, VALID, DATA_OUT_A, DATA_OUT_B);
        end
        tick();
        RST = 1'b0;
        repeat (5) tick();
        checks++;
        if (BUSY !== 1'b1) begin
            errors++;
            $display("FAIL mid_scrub_busy: got BUSY=%b, want 1", BUSY);
        end
        RST = 1'b1;
        tick();
        clear_model();
        run_scrub("restart", 1'b0);
        drive(1'b1, 1'b0, 4'd0, 16'h0, 1'b1, 4'd9, 4'd3);
        e = exp_q.pop_front();
        checks++;
        if ({VALID, DATA_OUT_A, DATA_OUT_B} !== {1'b1, 16'h0000, 16'h0000}) begin
            errors++;
            $display("FAIL after_restart: got V=%b A=%h B=%h, want V=1 A=0000 B=0000",
                     VALID, DATA_OUT_A, DATA_OUT_B);
        end
    endtask

    initial begin
        test_reset();
        test_scrub_readback();
        test_write_read();
        test_same_addr();
        test_disable();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
